// File: rtl/alu_ser_pkg.sv
// Shared constants for the ALU result serializer: state encoding, default widths
// and the beat-count / beat-counter-width helpers.
package alu_ser_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam int DEF_INPUT_WIDTH  = 16;
  localparam int DEF_OUTPUT_WIDTH = 8;

  function automatic int beats_of(input int input_width, input int output_width);
    return input_width / output_width;
  endfunction

  // A single-beat configuration still needs a one-bit counter to stay legal.
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// Byte stream from the serializer to the TX FIFO write port.
// A beat moves on a rising clk edge where tx_valid & tx_ready; tx_data/tx_valid hold steady until then.
interface alu_result_serializer_if
  import alu_ser_pkg::*;
#(
  parameter int output_width = DEF_OUTPUT_WIDTH
);
  logic [output_width-1:0] tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/alu_result_serializer_rise_detect.sv
// One-flop rising-edge detector for level flags; a flag high out of reset reads as a rise.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_d <= 1'b0;
    else     in_d <= in;
  end

  assign rise = in & ~in_d;

endmodule

// File: rtl/alu_result_serializer.sv
// Captures an ALU result on the rise of its done flag and streams it out one beat per handshake.
// Define MSB_FIRST_EN to send the most significant slice first (default is LSB first).
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int input_width  = DEF_INPUT_WIDTH,
  parameter int output_width = DEF_OUTPUT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [input_width-1:0] res_in,
  input  logic                   res_flag,
  input  logic                   overrun_clr,
  alu_result_serializer_if.master tx,
  output logic                   busy,
  output logic                   overrun,
  output logic [0:0]             state_dbg
);

  localparam int BEATS = beats_of(input_width, output_width);
  localparam int BW    = beat_cnt_width(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [0:0]              state;
  logic [BW-1:0]           beat;
  logic [input_width-1:0]  hold;
  logic [output_width-1:0] data_q;
  logic                    rise;
  logic                    final_xfer;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .in   (res_flag),
    .rise (rise)
  );

  function automatic logic [output_width-1:0] pick(input logic [input_width-1:0] word,
                                                   input logic [BW-1:0] idx);
    int sel;
    logic [input_width-1:0] shifted;
`ifdef MSB_FIRST_EN
    sel = BEATS - 1 - int'(idx);
`else
    sel = int'(idx);
`endif
    shifted = word >> (sel * output_width);
    return shifted[output_width-1:0];
  endfunction

  assign final_xfer = (state == SEND) && tx.tx_ready && (beat == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      hold   <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            hold   <= res_in;
            beat   <= '0;
            data_q <= pick(res_in, '0);
            state  <= SEND;
          end
        end
        default: begin
          if (tx.tx_ready) begin
            if (beat == LAST_BEAT) begin
              // A rise landing on the final transfer chains straight into the next result.
              if (rise) begin
                hold   <= res_in;
                beat   <= '0;
                data_q <= pick(res_in, '0);
              end else begin
                state <= IDLE;
              end
            end else begin
              beat   <= beat + 1'b1;
              data_q <= pick(hold, beat + 1'b1);
            end
          end
        end
      endcase
    end
  end

  // Set has priority over clear so a dropped result is never silently forgotten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         overrun <= 1'b0;
    else if ((state == SEND) && rise && !final_xfer) overrun <= 1'b1;
    else if (overrun_clr)                            overrun <= 1'b0;
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = (state == SEND);
  assign busy        = (state == SEND);
  assign state_dbg   = state;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer: directed scenarios plus a randomized run
// against a queue-based model of the byte stream. Honours MSB_FIRST_EN like the design.
module tb_alu_result_serializer;

  localparam int IW    = 16;
  localparam int OW    = 8;
  localparam int BEATS = IW / OW;

  logic          clk;
  logic          rst;
  logic [IW-1:0] res_in;
  logic          res_flag;
  logic          overrun_clr;
  logic          tx_ready;
  logic          busy;
  logic          overrun;
  logic [0:0]    state_dbg;

  alu_result_serializer_if #(.output_width(OW)) tx_if ();
  assign tx_if.tx_ready = tx_ready;

  alu_result_serializer #(.input_width(IW), .output_width(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .res_in      (res_in),
    .res_flag    (res_flag),
    .overrun_clr (overrun_clr),
    .tx          (tx_if),
    .busy        (busy),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: bytes still owed downstream, sticky overrun, last presented byte
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] sent_q[$];
  logic          m_ovr;
  logic          m_flag;
  logic [OW-1:0] m_last;

  logic          obs_valid, obs_busy, obs_ovr;
  logic [OW-1:0] obs_data;
  logic          exp_valid, exp_ovr;
  logic [OW-1:0] exp_data;

  task automatic model_reset();
    exp_q.delete();
    m_ovr  = 1'b0;
    m_flag = 1'b0;
    m_last = '0;
  endtask

  task automatic push_result(input logic [IW-1:0] w);
    for (int i = 0; i < BEATS; i++) begin
      int idx;
`ifdef MSB_FIRST_EN
      idx = BEATS - 1 - i;
`else
      idx = i;
`endif
      exp_q.push_back(OW'(w >> (idx * OW)));
    end
  endtask

  // Samples DUT and model at the negedge, then advances the model and the clock one cycle.
  task automatic cycle();
    logic          rise;
    logic          set_ovr;
    logic [OW-1:0] dropped;
    obs_valid = tx_if.tx_valid;
    obs_busy  = busy;
    obs_ovr   = overrun;
    obs_data  = tx_if.tx_data;
    exp_valid = (exp_q.size() != 0);
    exp_data  = exp_valid ? exp_q[0] : m_last;
    m_last    = exp_data;
    exp_ovr   = m_ovr;
    if (obs_valid && tx_ready) sent_q.push_back(obs_data);
    if (exp_q.size() != 0 && tx_ready) dropped = exp_q.pop_front();
    rise   = res_flag && !m_flag;
    m_flag = res_flag;
    set_ovr = 1'b0;
    if (rise) begin
      if (exp_q.size() == 0) push_result(res_in);
      else                   set_ovr = 1'b1;
    end
    if (set_ovr)          m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle_inputs();
    res_flag    = 1'b0;
    overrun_clr = 1'b0;
    tx_ready    = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    res_in = '0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || tx_if.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b busy=%b ovr=%b data=%h, required 0 0 0 00",
               tx_if.tx_valid, busy, overrun, tx_if.tx_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int busy_cycles;
    logic [OW-1:0] want[2];
`ifdef MSB_FIRST_EN
    want = '{8'hA5, 8'h5A};
`else
    want = '{8'h5A, 8'hA5};
`endif
    sent_q.delete();
    busy_cycles = 0;
    res_in = 16'hA55A;
    for (int c = 0; c < 9; c++) begin
      res_flag = (c < 5);
      cycle();
      if (obs_busy) busy_cycles++;
      n_checks++;
      if (obs_valid !== exp_valid || obs_busy !== exp_valid || obs_data !== exp_data || obs_ovr !== exp_ovr) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: valid=%b busy=%b data=%h ovr=%b, required valid=%b busy=%b data=%h ovr=%b",
                 c, obs_valid, obs_busy, obs_data, obs_ovr, exp_valid, exp_valid, exp_data, exp_ovr);
      end
    end
    n_checks++;
    if (sent_q.size() != 2 || sent_q[0] !== want[0] || sent_q[1] !== want[1]) begin
      n_fail++;
      $display("FAIL basic_beats: got %0d beats first=%h, required 2 beats %h %h",
               sent_q.size(), (sent_q.size() > 0) ? sent_q[0] : 8'hxx, want[0], want[1]);
    end
    n_checks++;
    if (busy_cycles != 2) begin
      n_fail++;
      $display("FAIL basic_busy_len: busy for %0d cycles, required 2", busy_cycles);
    end
  endtask

  task automatic test_stall();
    logic [OW-1:0] want0;
`ifdef MSB_FIRST_EN
    want0 = 8'hA5;
`else
    want0 = 8'h5A;
`endif
    sent_q.delete();
    res_in = 16'hA55A;
    res_flag = 1'b1;
    tx_ready = 1'b0;
    cycle();
    res_flag = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tx_ready = (c >= 4);
      cycle();
      n_checks++;
      if (obs_valid !== exp_valid || obs_data !== exp_data || obs_busy !== exp_valid) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: valid=%b data=%h, required valid=%b data=%h",
                 c, obs_valid, obs_data, exp_valid, exp_data);
      end
      if (c < 4) begin
        n_checks++;
        if (obs_valid !== 1'b1 || obs_data !== want0) begin
          n_fail++;
          $display("FAIL stall_hold%0d: valid=%b data=%h, required 1 %h", c, obs_valid, obs_data, want0);
        end
      end
    end
    n_checks++;
    if (sent_q.size() != 2 || sent_q[0] !== want0) begin
      n_fail++;
      $display("FAIL stall_beats: got %0d beats, required 2 starting %h", sent_q.size(), want0);
    end
  endtask

  task automatic test_overrun();
    logic [OW-1:0] want[2];
`ifdef MSB_FIRST_EN
    want = '{8'h12, 8'h34};
`else
    want = '{8'h34, 8'h12};
`endif
    sent_q.delete();
    tx_ready = 1'b0;
    res_in = 16'h1234; res_flag = 1'b1; cycle();
    res_flag = 1'b0; cycle();
    res_in = 16'hFFFF; res_flag = 1'b1; cycle();
    n_checks++;
    if (overrun !== 1'b1 || m_ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: overrun=%b, required 1", overrun);
    end
    res_flag = 1'b0; overrun_clr = 1'b1; cycle();
    overrun_clr = 1'b0; cycle();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
    end
    res_flag = 1'b1; overrun_clr = 1'b1; cycle();
    res_flag = 1'b0; overrun_clr = 1'b0; cycle();
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set_wins: overrun=%b, required 1", overrun);
    end
    tx_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      n_checks++;
      if (obs_data !== exp_data || obs_valid !== exp_valid || obs_ovr !== exp_ovr) begin
        n_fail++;
        $display("FAIL overrun_drain%0d: data=%h valid=%b ovr=%b, required %h %b %b",
                 c, obs_data, obs_valid, obs_ovr, exp_data, exp_valid, exp_ovr);
      end
    end
    n_checks++;
    if (sent_q.size() != 2 || sent_q[0] !== want[0] || sent_q[1] !== want[1]) begin
      n_fail++;
      $display("FAIL overrun_beats: got %0d beats, required %h %h", sent_q.size(), want[0], want[1]);
    end
    overrun_clr = 1'b1; cycle();
    overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] want[4];
`ifdef MSB_FIRST_EN
    want = '{8'h00, 8'hFF, 8'hBE, 8'hEF};
`else
    want = '{8'hFF, 8'h00, 8'hEF, 8'hBE};
`endif
    sent_q.delete();
    tx_ready = 1'b1;
    res_in = 16'h00FF; res_flag = 1'b1; cycle();
    res_flag = 1'b0; cycle();
    res_in = 16'hBEEF; res_flag = 1'b1; cycle();
    res_flag = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      n_checks++;
      if (obs_valid !== exp_valid || obs_data !== exp_data || obs_ovr !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: valid=%b data=%h ovr=%b, required %b %h 0",
                 c, obs_valid, obs_data, obs_ovr, exp_valid, exp_data);
      end
    end
    n_checks++;
    if (sent_q.size() != 4 || sent_q[0] !== want[0] || sent_q[1] !== want[1] ||
        sent_q[2] !== want[2] || sent_q[3] !== want[3]) begin
      n_fail++;
      $display("FAIL b2b_beats: got %0d beats, required %h %h %h %h",
               sent_q.size(), want[0], want[1], want[2], want[3]);
    end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b1;
    res_in = 16'hCAFE; res_flag = 1'b1; cycle();
    res_flag = 1'b0; cycle();
    tx_ready = 1'b0; cycle();
    res_flag = 1'b1; cycle();
    n_checks++;
    if (overrun !== 1'b1 || tx_if.tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: overrun=%b valid=%b, required 1 1", overrun, tx_if.tx_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || tx_if.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%b busy=%b ovr=%b data=%h, required 0 0 0 00",
               tx_if.tx_valid, busy, overrun, tx_if.tx_data);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sent_q.delete();
    res_in = 16'h1357;
    tx_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      n_checks++;
      if (obs_valid !== exp_valid || obs_data !== exp_data || obs_busy !== exp_valid || obs_ovr !== exp_ovr) begin
        n_fail++;
        $display("FAIL rstmid_after%0d: valid=%b data=%h ovr=%b, required %b %h %b",
                 c, obs_valid, obs_data, obs_ovr, exp_valid, exp_data, exp_ovr);
      end
    end
    n_checks++;
    if (!(sent_q.size() > 0 && (sent_q[0] === 8'h57 || sent_q[0] === 8'h13))) begin
      n_fail++;
      $display("FAIL rstmid_recapture: got %0d beats after release, required a capture of 1357", sent_q.size());
    end
    res_flag = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) res_in = IW'($urandom);
      res_flag    = ($urandom_range(0, 2) == 0);
      tx_ready    = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 9) == 0);
      cycle();
      n_checks++;
      if (obs_valid !== exp_valid || obs_busy !== exp_valid || obs_data !== exp_data || obs_ovr !== exp_ovr) begin
        n_fail++;
        $display("FAIL random_cycle%0d: valid=%b busy=%b data=%h ovr=%b, required valid=%b data=%h ovr=%b",
                 c, obs_valid, obs_busy, obs_data, obs_ovr, exp_valid, exp_data, exp_ovr);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Consumer end of the ALU result interface.
- Captures a wide ALU result, such as the shift unit's 16-bit output, when its done flag rises.
- Sends the captured result to the UART TX path one byte per valid/ready handshake.
- Sits between the ALU and the TX-side FIFO write port, in the clk domain.

Parameters:
- input_width, 16: width of the ALU result word.
- output_width, 8: width of one transmitted beat. input_width must be an integer multiple of it.
- BEATS, input_width/output_width: beats per result (derived localparam, not overridable).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- res_in  input  input_width  ALU result word.
- res_flag  input  1  ALU result-valid flag. Level signal; may stay high for many cycles.
- tx_ready  input  1  downstream can accept a beat this cycle (FIFO not full).
- overrun_clr  input  1  single-cycle pulse; clears overrun.
- tx_data  output  output_width  current beat.
- tx_valid  output  1  tx_data is valid.
- busy  output  1  a result is held and not yet fully sent.
- overrun  output  1  sticky; a result was dropped.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, beat counter=0, hold register=0, flag_d=0.
  - tx_data=0, tx_valid=0, busy=0, overrun=0.
  - Any partially sent result is discarded.
- Capture event is rise = res_flag & ~flag_d. flag_d is res_flag registered every cycle.
  - A flag already high when reset releases counts as a rise on the first edge.
  - A held-high flag produces exactly one capture.
- States: IDLE and SEND.
- IDLE:
  - On rise at an edge: hold <= res_in, beat <= 0, state <= SEND.
  - tx_valid and busy go high after that same edge. Latency is one cycle from the rise being sampled to the first beat being presented.
- SEND:
  - tx_valid=1, busy=1.
  - tx_data = hold slice selected by beat. Default is LSB first: beat 0 = hold[output_width-1:0].
  - A beat transfers at an edge where tx_valid & tx_ready. tx_data must stay stable while tx_ready=0, with no timeout.
  - Non-final beat transfers: beat increments.
  - Final beat (beat==BEATS-1) transfers:
    - If rise is also present at that edge, capture the new result, set beat=0 and stay in SEND. This gives zero gap between results.
    - Otherwise go to IDLE; tx_valid and busy drop after that edge.
- Overrun:
  - A rise in SEND that does not coincide with the final-beat transfer sets overrun=1.
  - The new res_in is dropped; hold is unaffected.
  - overrun_clr clears it. If set and clear occur at the same edge, set wins.
- tx_data:
  - Registered.
  - Keeps its last value in IDLE; not cleared.
- Throughput: with tx_ready held high, one beat per cycle, so a 16-bit result takes 2 cycles.

Optional Feature:
- Macro MSB_FIRST_EN.
- Defined: beat 0 = hold[input_width-1:input_width-output_width]; later beats descend toward the LSB.
- Undefined: LSB-first order as above.
- Handshake, latency and flags are identical in both builds.

Decomposition:
- Package alu_ser_pkg:
  - State encoding localparams (IDLE=1'b0, SEND=1'b1).
  - Default widths.
  - BEATS derivation function (clog2 for the beat counter width).
- Sub-module rise_detect: a one-flop edge detector (clk, rst, in, rise). It is reused for other level flags in the controller.
- Beat mux and FSM stay in the top module.

Test Plan:
- Reset, then res_in=16'hA55A and res_flag 0->1 held high for 5 cycles, tx_ready=1:
  - Exactly two beats: 8'h5A then 8'hA5 on consecutive cycles.
  - busy high for 2 cycles; no third beat.
- Same capture with tx_ready=0 for 4 cycles, then 1:
  - tx_data holds 8'h5A and tx_valid stays high through the stall.
  - Then 8'h5A, 8'hA5 transfer.
- Capture 16'h1234, hold tx_ready=0, pulse a rise with res_in=16'hFFFF:
  - overrun=1; the beats sent are still 8'h34, 8'h12.
  - overrun_clr pulse returns overrun to 0.
  - Coincident rise and overrun_clr leaves overrun=1.
- Rise with 16'h00FF, second rise with 16'hBEEF exactly at the final-beat transfer:
  - Beats sent are 8'hFF, 8'h00, 8'hEF, 8'hBE with no idle cycle.
  - overrun stays 0.
- Assert rst after the first beat of 16'hCAFE:
  - tx_valid, busy and overrun go to 0 immediately.
  - After release with res_flag held high, a new capture occurs on the first edge.
- Build with MSB_FIRST_EN and 16'hA55A: beats 8'hA5 then 8'h5A.
